// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a per-ownership hold limit.
// Grant, grant index and timeout pulse are all registered outputs.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  state_t     state_q;
  logic [1:0] ptr_q;
  logic [1:0] gnt_id_q;
  logic [3:0] gnt_q;
  logic [7:0] hold_cnt_q;
  logic       timeout_q;

  logic [3:0] cand_d;
  logic       win_vld_d;
  logic [1:0] win_id_d;
  logic       owner_req_d;
  logic       at_limit_d;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // The current owner is excluded from the search so release and limit both hand off.
  always_comb begin
    cand_d      = req;
    if (state_q == GRANT) cand_d = req & ~onehot(gnt_id_q);
    {win_vld_d, win_id_d} = rr_pick(cand_d, ptr_q);
    owner_req_d = req[gnt_id_q];
    at_limit_d  = (hold_cnt_q >= MAX_HOLD_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      gnt_id_q   <= 2'd0;
      gnt_q      <= 4'b0000;
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q    <= GRANT;
            gnt_q      <= onehot(win_id_d);
            gnt_id_q   <= win_id_d;
            ptr_q      <= win_id_d + 2'd1;
            hold_cnt_q <= 8'd1;
          end
        end
        GRANT: begin
          if (owner_req_d && !at_limit_d) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end else if (win_vld_d) begin
            // Release has precedence over the limit, so timeout only on a forced handoff.
            gnt_q      <= onehot(win_id_d);
            gnt_id_q   <= win_id_d;
            ptr_q      <= win_id_d + 2'd1;
            hold_cnt_q <= 8'd1;
            timeout_q  <= owner_req_d;
          end else if (owner_req_d) begin
            hold_cnt_q <= 8'd1;
          end else begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            hold_cnt_q <= 8'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4: directed scenarios plus random traffic against
// a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int MAXH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int n_checks;
  int n_fail;

  // Model state: owner index or -1 when nobody owns the resource.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_tmo;
  bit m_in_reset;

  rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int mdl_search(input logic [3:0] r, input int start, input int excl);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (c != excl && r[c]) return c;
    end
    return -1;
  endfunction

  task automatic mdl_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_tmo   = 0;
  endtask

  task automatic mdl_update(input logic [3:0] r);
    int  w;
    bit  released;
    m_tmo = 0;
    if (m_owner < 0) begin
      w = mdl_search(r, m_ptr, -1);
      if (w >= 0) begin
        m_owner = w; m_hold = 1; m_ptr = (w + 1) % 4;
      end
    end else if (r[m_owner] && m_hold < MAXH) begin
      m_hold++;
    end else begin
      released = !r[m_owner];
      w = mdl_search(r, m_ptr, m_owner);
      if (w >= 0) begin
        m_owner = w; m_hold = 1; m_ptr = (w + 1) % 4;
        m_tmo = !released;
      end else if (released) begin
        m_owner = -1; m_hold = 0;
      end else begin
        m_hold = 1;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_vld"}, 32'(gnt_valid), 32'(m_owner >= 0));
    chk({tag, "_tmo"}, 32'(timeout), 32'(m_tmo));
    if (m_owner >= 0)   chk({tag, "_id"}, 32'(gnt_id), 32'(m_owner));
    else if (m_in_reset) chk({tag, "_id"}, 32'(gnt_id), 32'd0);
  endtask

  // One clock: drive req (and release reset) at the falling edge, check after the rising edge.
  task automatic step(input logic [3:0] r, input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    m_in_reset = 0;
    req = r;
    @(posedge clk);
    mdl_update(r);
    #1;
    check_outputs(tag);
  endtask

  task automatic apply_reset(input logic [3:0] r, input int ncyc);
    @(negedge clk);
    rst_n = 1'b0;
    req = r;
    mdl_reset();
    m_in_reset = 1;
    #1;
    check_outputs("rst");
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      check_outputs("rst_hold");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    mdl_reset();
    m_in_reset = 1;

    // Reset with all requests asserted, then first grant goes to requester 0.
    apply_reset(4'b1111, 3);
    step(4'b1111, "rst_rel");
    chk("rst_rel_gnt0", 32'(gnt), 32'h1);

    // Single request from idle, release, then search resumes at index 3.
    apply_reset(4'b0000, 1);
    step(4'b0000, "idle");
    step(4'b0100, "single");
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_id", 32'(gnt_id), 32'd2);
    step(4'b0000, "single_rel");
    step(4'b0000, "single_idle");
    chk("single_zero", 32'(gnt), 32'h0);
    step(4'b1001, "single_ptr");
    chk("single_ptr3", 32'(gnt), 32'h8);

    // Full contention: each requester holds exactly MAXH cycles.
    apply_reset(4'b0000, 1);
    for (int k = 0; k < 17; k++) begin
      step(4'b1111, "fc");
      chk("fc_gnt", 32'(gnt), 32'(4'b0001 << ((k / MAXH) % 4)));
      chk("fc_tmo", 32'(timeout), 32'(k > 0 && (k % MAXH) == 0));
    end

    // Lone holder keeps the grant past the limit, never times out.
    apply_reset(4'b0000, 1);
    for (int k = 0; k < 12; k++) begin
      step(4'b1000, "lone");
      chk("lone_gnt", 32'(gnt), 32'h8);
      chk("lone_tmo", 32'(timeout), 32'd0);
    end

    // Back-to-back release: no idle bubble between owners.
    apply_reset(4'b0000, 1);
    step(4'b0001, "b2b");
    step(4'b0001, "b2b");
    step(4'b1010, "b2b_hand");
    chk("b2b_gnt1", 32'(gnt), 32'h2);
    step(4'b1000, "b2b_hand2");
    chk("b2b_gnt3", 32'(gnt), 32'h8);

    // Reset mid-grant clears outputs asynchronously.
    apply_reset(4'b0000, 1);
    step(4'b0100, "mid");
    chk("mid_gnt2", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    mdl_reset();
    m_in_reset = 1;
    #1;
    chk("mid_async_gnt", 32'(gnt), 32'h0);
    chk("mid_async_vld", 32'(gnt_valid), 32'd0);
    step(4'b1001, "mid_rel");
    chk("mid_rel_gnt0", 32'(gnt), 32'h1);
    step(4'b1000, "mid_next");
    chk("mid_next_gnt3", 32'(gnt), 32'h8);

    // Random traffic with sticky request patterns and occasional resets.
    begin
      logic [3:0] r;
      r = 4'b0000;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(59) == 0) apply_reset(4'($urandom_range(15)), 1);
        if ($urandom_range(3) == 0) r = 4'($urandom_range(15));
        step(r, "rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Guard against a hang regardless of DUT behaviour.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
